// File: rtl/gshare_predictor_if.sv
// Prediction and resolution bundle between fetch/execute and the gshare predictor.
// The master drives requests and resolutions; the slave (predictor) returns direction and history.
interface gshare_predictor_if #(
  parameter int GHR_BITS = 6
);
  logic                pred_valid;
  logic [31:0]         pred_pc;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                resolve_valid;
  logic [31:0]         resolve_pc;
  logic [GHR_BITS-1:0] resolve_ghr;
  logic                resolve_taken;
  logic                resolve_mispredict;

  modport master (
    output pred_valid, pred_pc,
    output resolve_valid, resolve_pc, resolve_ghr, resolve_taken, resolve_mispredict,
    input  pred_taken, pred_ghr
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  resolve_valid, resolve_pc, resolve_ghr, resolve_taken, resolve_mispredict,
    output pred_taken, pred_ghr
  );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: 2-bit counter PHT indexed by PC ^ speculative global history.
// Define GSHARE_PHT_BYPASS_EN to forward a same-cycle PHT update into the prediction read.
module gshare_predictor #(
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_BITS    = 6
) (
  input  logic               clock,
  input  logic               reset,
  gshare_predictor_if.slave  bp
);
  localparam int IDX_BITS = $clog2(PHT_ENTRIES);

  logic [1:0]          pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS-1:0] ghr_next;
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic [1:0]          pred_cnt;
  logic [1:0]          res_cnt_next;

  function automatic logic [1:0] train(input logic [1:0] cnt, input logic taken);
    logic [1:0] result;
    result = cnt;
    if (taken && cnt != 2'b11)
      result = cnt + 2'd1;
    else if (!taken && cnt != 2'b00)
      result = cnt - 2'd1;
    return result;
  endfunction

  function automatic logic [GHR_BITS-1:0] shift_in(input logic [GHR_BITS-1:0] hist, input logic bit_in);
    logic [GHR_BITS:0] wide;
    wide = {hist, bit_in};
    return wide[GHR_BITS-1:0];
  endfunction

  assign pred_idx     = bp.pred_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr);
  assign res_idx      = bp.resolve_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.resolve_ghr);
  assign res_cnt_next = train(pht[res_idx], bp.resolve_taken);

  // A training write to the same entry in this cycle is forwarded only in the bypass build
  always_comb begin
    pred_cnt = pht[pred_idx];
`ifdef GSHARE_PHT_BYPASS_EN
    if (bp.resolve_valid && !reset && res_idx == pred_idx)
      pred_cnt = res_cnt_next;
`endif
  end

  assign bp.pred_taken = pred_cnt[1];
  assign bp.pred_ghr   = ghr;

  // Mispredict repair wins over the speculative shift; the same-cycle prediction is squashed
  always_comb begin
    ghr_next = ghr;
    if (bp.resolve_valid && bp.resolve_mispredict)
      ghr_next = shift_in(bp.resolve_ghr, bp.resolve_taken);
    else if (bp.pred_valid)
      ghr_next = shift_in(ghr, bp.pred_taken);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ghr <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht[i] <= 2'b00;
    end else begin
      ghr <= ghr_next;
      if (bp.resolve_valid)
        pht[res_idx] <= res_cnt_next;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pred_pc[31:IDX_BITS+2], bp.pred_pc[1:0],
                            bp.resolve_pc[31:IDX_BITS+2], bp.resolve_pc[1:0]};
endmodule
